// File: rtl/arb_bram_responder_if.sv
// Client-side bus of the arbiter memory protocol: request/write/address/data in,
// ack/err pulses, read words with valid, and a busy level back.
interface arb_bram_responder_if #(
    parameter int unsigned AN = 24,
    parameter int unsigned DN = 16
);
    logic          req;
    logic          wr;
    logic [AN-1:0] addr;
    logic [DN-1:0] data;
    logic          ack;
    logic [DN-1:0] data_out;
    logic          valid;
    logic          busy;
    logic          err;

    modport master (
        output req, wr, addr, data,
        input  ack, data_out, valid, busy, err
    );

    modport slave (
        input  req, wr, addr, data,
        output ack, data_out, valid, busy, err
    );
endinterface

// File: rtl/arb_bram_responder.sv
// Block-RAM responder for the arbiter client protocol: single-word writes and
// BURST-word wrapping reads inside a 2^MEM_AW-word window starting at BASE.
module arb_bram_responder #(
    parameter int unsigned   AN     = 24,
    parameter int unsigned   DN     = 16,
    parameter int unsigned   BURST  = 8,
    parameter int unsigned   MEM_AW = 10,
    parameter logic [AN-1:0] BASE   = 24'hfa0000,
    parameter int unsigned   LAT    = 2
) (
    input  logic                 clkSYS,
    input  logic                 reset,
    arb_bram_responder_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam int unsigned LCW   = $clog2(LAT + 1);
    localparam int unsigned BW    = $clog2(BURST + 1);

    // One extra bit so the window end cannot overflow the address width
    localparam logic [AN:0] WIN_LO = {1'b0, BASE};
    localparam logic [AN:0] WIN_HI = WIN_LO + (AN+1)'(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACK    = 2'd1;
    localparam logic [1:0] RWAIT  = 2'd2;
    localparam logic [1:0] RBURST = 2'd3;

    logic [1:0]        state, state_n;
    logic              is_read, is_read_n;
    logic              oow, oow_n;
    logic [MEM_AW-1:0] ptr, ptr_n;
    logic [LCW-1:0]    cnt, cnt_n;
    logic [BW-1:0]     beat, beat_n;
    logic              ack_n, err_n, valid_n, busy_n;

    logic              in_win_c;
    logic [MEM_AW-1:0] index_c;
    logic              mem_we_c;
    logic              load_c;

    logic [DN-1:0]     mem [DEPTH];

    assign in_win_c = ({1'b0, bus.addr} >= WIN_LO) && ({1'b0, bus.addr} < WIN_HI);
    assign index_c  = MEM_AW'(bus.addr - BASE);

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        is_read_n = is_read;
        oow_n     = oow;
        ptr_n     = ptr;
        cnt_n     = cnt;
        beat_n    = beat;
        ack_n     = 1'b0;
        err_n     = 1'b0;
        valid_n   = 1'b0;
        mem_we_c  = 1'b0;
        load_c    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_n   = ACK;
                    ack_n     = 1'b1;
                    err_n     = !in_win_c;
                    oow_n     = !in_win_c;
                    is_read_n = !bus.wr;
                    ptr_n     = index_c;
                    mem_we_c  = bus.wr && in_win_c;
                end
            end
            ACK: begin
                if (!is_read) begin
                    state_n = IDLE;
                end else if (LAT > 1) begin
                    state_n = RWAIT;
                    cnt_n   = LCW'(LAT - 2);
                end else begin
                    state_n = RBURST;
                    load_c  = 1'b1;
                    valid_n = 1'b1;
                    beat_n  = '0;
                    ptr_n   = ptr + MEM_AW'(1);
                end
            end
            RWAIT: begin
                if (cnt == '0) begin
                    state_n = RBURST;
                    load_c  = 1'b1;
                    valid_n = 1'b1;
                    beat_n  = '0;
                    ptr_n   = ptr + MEM_AW'(1);
                end else begin
                    cnt_n = cnt - LCW'(1);
                end
            end
            RBURST: begin
                if (beat == BW'(BURST - 1)) begin
                    state_n = IDLE;
                end else begin
                    load_c  = 1'b1;
                    valid_n = 1'b1;
                    beat_n  = beat + BW'(1);
                    ptr_n   = ptr + MEM_AW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State, control and registered outputs
    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            is_read      <= 1'b0;
            oow          <= 1'b0;
            ptr          <= '0;
            cnt          <= '0;
            beat         <= '0;
            bus.ack      <= 1'b0;
            bus.err      <= 1'b0;
            bus.valid    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.data_out <= '0;
        end else begin
            state     <= state_n;
            is_read   <= is_read_n;
            oow       <= oow_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            beat      <= beat_n;
            bus.ack   <= ack_n;
            bus.err   <= err_n;
            bus.valid <= valid_n;
            bus.busy  <= busy_n;
            if (load_c) begin
                bus.data_out <= oow ? '0 : mem[ptr];
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clkSYS) begin
        if (mem_we_c) begin
            mem[index_c] <= bus.data;
        end
    end

endmodule

// File: tb/tb_arb_bram_responder.sv
// Self-checking bench for arb_bram_responder: directed protocol scenarios plus
// randomized traffic compared against an array-based memory model.
module tb_arb_bram_responder;

    localparam int unsigned AN     = 24;
    localparam int unsigned DN     = 16;
    localparam int unsigned BURST  = 8;
    localparam int unsigned MEM_AW = 10;
    localparam int unsigned LAT    = 2;
    localparam int unsigned DEPTH  = 1 << MEM_AW;
    localparam logic [AN-1:0] BASE = 24'hfa0000;
    localparam int unsigned PERIOD = LAT + BURST + 1;

    logic clkSYS = 1'b0;
    logic reset;

    arb_bram_responder_if #(.AN(AN), .DN(DN)) bus ();

    arb_bram_responder #(
        .AN(AN), .DN(DN), .BURST(BURST), .MEM_AW(MEM_AW), .BASE(BASE), .LAT(LAT)
    ) u_dut (
        .clkSYS (clkSYS),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clkSYS = ~clkSYS;

    int checks = 0;
    int errors = 0;
    logic [DN-1:0] model [DEPTH];
    bit            known [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clkSYS);
        #1;
    endtask

    function automatic bit in_win(input logic [AN-1:0] a);
        int unsigned ua, ub;
        ua = int'(a);
        ub = int'(BASE);
        return (ua >= ub) && (ua < ub + DEPTH);
    endfunction

    function automatic int unsigned idx_of(input logic [AN-1:0] a);
        return (int'(a) - int'(BASE)) & (DEPTH - 1);
    endfunction

    // Write one word; returns in the first cycle a new request may be sampled
    task automatic do_write(input logic [AN-1:0] a, input logic [DN-1:0] d);
        check("wr_pre_busy", bus.busy, 0);
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.data = d;
        step();
        check("wr_ack", bus.ack, 1);
        check("wr_err", bus.err, !in_win(a));
        check("wr_busy", bus.busy, 1);
        bus.req = 1'b0; bus.wr = 1'(($urandom)); bus.addr = AN'($urandom); bus.data = DN'($urandom);
        step();
        check("wr_ack_end", bus.ack, 0);
        check("wr_err_end", bus.err, 0);
        check("wr_busy_end", bus.busy, 0);
        if (in_win(a)) begin
            model[idx_of(a)] = d;
            known[idx_of(a)] = 1'b1;
        end
    endtask

    // Read one burst with full timing checks
    task automatic do_read(input logic [AN-1:0] a);
        logic [DN-1:0] exp_w, last_w;
        bit            chk_w, last_k;
        int unsigned   ix;
        last_w = '0;
        last_k = 1'b0;
        bus.req = 1'b1; bus.wr = 1'b0; bus.addr = a;
        step();
        check("rd_ack", bus.ack, 1);
        check("rd_err", bus.err, !in_win(a));
        check("rd_busy", bus.busy, 1);
        check("rd_valid_at_ack", bus.valid, 0);
        bus.req = 1'b0; bus.addr = AN'($urandom);
        for (int i = 1; i < int'(LAT); i++) begin
            step();
            check("rd_wait_valid", bus.valid, 0);
            check("rd_wait_ack", bus.ack, 0);
        end
        for (int k = 0; k < int'(BURST); k++) begin
            step();
            check("rd_valid", bus.valid, 1);
            check("rd_busy_burst", bus.busy, 1);
            ix = (idx_of(a) + k) % DEPTH;
            if (!in_win(a)) begin
                exp_w = '0; chk_w = 1'b1;
            end else begin
                exp_w = model[ix]; chk_w = known[ix];
            end
            if (chk_w) check("rd_data", bus.data_out, exp_w);
            last_w = exp_w;
            last_k = chk_w;
        end
        step();
        check("rd_valid_end", bus.valid, 0);
        check("rd_busy_end", bus.busy, 0);
        if (last_k) check("rd_data_hold", bus.data_out, last_w);
    endtask

    initial begin
        logic [AN-1:0] ra;
        for (int i = 0; i < int'(DEPTH); i++) begin
            known[i] = 1'b0;
            model[i] = '0;
        end
        reset = 1'b1;
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data = '0;
        step();
        step();
        check("rst_ack", bus.ack, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_data", bus.data_out, 0);
        reset = 1'b0;
        step();

        // Basic write then read
        do_write(BASE + 24'd5, 16'h1234);
        do_write(BASE + 24'd6, 16'hABCD);
        do_read(BASE + 24'd5);

        // Wrap at the top of the window
        for (int i = 0; i < 8; i++) begin
            do_write(BASE + AN'((1021 + i) % DEPTH), DN'(16'h5000 + i * 16'h0111));
        end
        do_read(BASE + 24'd1021);

        // Out-of-window writes alias onto indices 1023 and 0 if the window check is broken
        do_write(BASE - 24'd1, 16'hDEAD);
        do_write(BASE + 24'd1024, 16'hBEEF);
        do_read(BASE + 24'd1021);
        do_read(BASE + 24'd1024);

        // Request held high across several bursts
        bus.req = 1'b1; bus.wr = 1'b0; bus.addr = BASE + 24'd5;
        for (int i = 0; i < 3 * int'(PERIOD); i++) begin
            int p;
            p = i % int'(PERIOD);
            check("held_ack", bus.ack, (p == 1));
            check("held_valid", bus.valid, (p >= int'(LAT) + 1) && (p <= int'(LAT + BURST)));
            check("held_busy", bus.busy, (p != 0));
            step();
        end
        bus.req = 1'b0;
        check("held_busy_gap", bus.busy, 0);
        step();

        // Write immediately followed by a read of the same word
        do_write(BASE + 24'd7, 16'hC0DE);
        do_read(BASE + 24'd7);

        // Reset in the middle of a burst, at word 3
        bus.req = 1'b1; bus.wr = 1'b0; bus.addr = BASE + 24'd1021;
        step();
        check("mid_ack", bus.ack, 1);
        bus.req = 1'b0;
        for (int i = 1; i < int'(LAT); i++) step();
        for (int k = 0; k < 4; k++) step();
        check("mid_valid", bus.valid, 1);
        check("mid_word3", bus.data_out, model[(1021 + 3) % DEPTH]);
        reset = 1'b1;
        #1;
        check("mid_rst_ack", bus.ack, 0);
        check("mid_rst_valid", bus.valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_err", bus.err, 0);
        check("mid_rst_data", bus.data_out, 0);
        step();
        check("mid_rst_valid_hold", bus.valid, 0);
        reset = 1'b0;
        do_read(BASE + 24'd5);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       ra = AN'($urandom);
                1:       ra = BASE - AN'($urandom_range(1, 4));
                2:       ra = BASE + AN'(DEPTH) + AN'($urandom_range(0, 4));
                default: ra = BASE + AN'($urandom_range(0, DEPTH - 1));
            endcase
            if (known[idx_of(ra)] && $urandom_range(0, 1) == 0) ra = BASE + AN'(idx_of(ra));
            if ($urandom_range(0, 9) < 6) do_write(ra, DN'($urandom));
            else                          do_read(ra);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                bus.wr = 1'($urandom); bus.addr = AN'($urandom);
                step();
                check("gap_idle", bus.busy, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
